key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 CLOCK_50  input  1  system clock; every register SHALL update on its rising edge.
REQ-003 reset  input  1  reset; asynchronous and active-high.
REQ-004 keys_pulse  input  4  one-cycle, active-high repeat pulses, one per push-button (bit i = button i).
REQ-005 clear_ovf  input  1  synchronous clear of the overflow flag.
REQ-006 ev_ready  input  1  consumer accepts the head event.
REQ-007 ev_valid  output  1  FIFO holds at least one event.
REQ-008 ev_code  output  2  button index of the head event.
REQ-009 count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-010 overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-011 Each keys_pulse[i] SHALL set a pending[i] bit at the rising edge on which it is sampled high.
REQ-012 The arbiter SHALL grant the lowest-index pending bit, combinationally from registered pending, when a push is permitted.
REQ-013 A push SHALL be permitted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-014 A granted bit SHALL clear at the edge. If keys_pulse[i] is high in that same cycle, the bit SHALL stay set as a new event.
REQ-015 A pulse on bit i while pending[i]=1 and bit i is not granted SHALL drop the event and set overflow.
REQ-016 A push SHALL write code i at the write pointer and advance it; pointers SHALL wrap modulo DEPTH.
REQ-017 A pop SHALL occur exactly when ev_valid && ev_ready. It SHALL advance the read pointer.
REQ-018 ev_valid SHALL equal (count!=0); ev_code SHALL be the head entry, stable while ev_valid && !ev_ready.
REQ-019 count SHALL be +1 for push only, -1 for pop only, and unchanged for push+pop or neither.
REQ-020 When empty, ev_code SHALL be 0 and ev_ready SHALL be ignored; no underflow.
REQ-021 Latency: a pulse sampled at edge k on an empty queue with nothing pending SHALL give ev_valid=1 and the matching ev_code after edge k+1.
REQ-022 Throughput SHALL be at most one push and at most one pop per cycle. Simultaneous pulses SHALL be serialized in index order 0,1,2,3 on consecutive cycles.
REQ-023 overflow SHALL stay set until reset, or until clear_ovf=1 with no new drop that cycle. A drop and clear_ovf in the same cycle SHALL leave overflow set.

Reset
REQ-024 On reset assertion, all state SHALL clear immediately: pending=0, pointers=0, count=0, ev_valid=0, ev_code=0, overflow=0.
REQ-025 Reset mid-operation SHALL discard all queued and pending events. No event SHALL be emitted for pulses sampled while reset=1.
REQ-026 After reset deasserts, the first rising edge SHALL sample keys_pulse normally.

Structure
REQ-027 A shared package SHALL hold:
- the key-code constants KEY0..KEY3 = 0..3
- the key-count constant 4
- the default DEPTH
REQ-028 The FIFO SHALL be a sub-module, sync_fifo, parameterized by width and DEPTH, with push/pop/count/full/empty.
REQ-029 The pending register and the fixed-priority arbiter SHALL reside in key_event_queue.

Verification
REQ-030 Single event: keys_pulse=4'b0100 for 1 cycle, ev_ready=1 -> ev_valid for exactly 1 cycle, ev_code=2, count 0->1->0.
REQ-031 Simultaneous: keys_pulse=4'b1111 for 1 cycle, ev_ready=0 -> count reaches 4 after 4 edges, then pops yield codes 0,1,2,3 in order.
REQ-032 Full plus backpressure: 9 separated pulses on bit 1, ev_ready=0, DEPTH=8 -> count=8, ev_valid=1, overflow=0, and pending[1] is held. A 10th pulse sets overflow=1.
REQ-033 Full with concurrent pop: count=8, pending[3]=1, ev_ready=1 for 1 cycle -> count stays 8 and code 3 is at the tail.
REQ-034 Overflow clear: overflow=1, clear_ovf=1 for 1 cycle -> overflow=0. Repeat with a drop in the same cycle -> overflow remains 1.
REQ-035 Reset mid-stream: count=5 and pending=4'b0011, assert reset asynchronously -> all outputs 0 before the next edge. After release, no stale events appear.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared constants for the push-button event queue: key codes, key count and
// the default FIFO depth.
package key_event_queue_pkg;

    localparam int unsigned KEY_COUNT     = 4;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef logic [1:0] key_code_t;

    localparam key_code_t KEY0 = 2'd0;
    localparam key_code_t KEY1 = 2'd1;
    localparam key_code_t KEY2 = 2'd2;
    localparam key_code_t KEY3 = 2'd3;

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Power-of-two depth lets the pointers wrap by plain overflow.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Push-button event queue: per-key pending bits, a fixed-priority arbiter
// (key 0 highest) feeding a FIFO of key codes, and a sticky drop flag.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [KEY_COUNT-1:0]   keys_pulse,
    input  logic                   clear_ovf,
    input  logic                   ev_ready,
    output logic                   ev_valid,
    output logic [1:0]             ev_code,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    logic [KEY_COUNT-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic [KEY_COUNT-1:0] grant;
    key_code_t            grant_code;
    logic                 push;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign push_ok  = !fifo_full || pop;
    assign overflow = overflow_q;

    always_comb begin
        grant      = '0;
        grant_code = KEY0;
        push       = 1'b0;
        for (int unsigned i = 0; i < KEY_COUNT; i++) begin
            if (push_ok && pending_q[i] && !push) begin
                grant[i]   = 1'b1;
                grant_code = key_code_t'(i);
                push       = 1'b1;
            end
        end
    end

    // A pulse on the key just granted re-arms its pending bit as a new event;
    // a pulse on any other already-pending key is lost.
    always_comb begin
        pending_d  = (pending_q & ~grant) | keys_pulse;
        drop       = |(keys_pulse & pending_q & ~grant);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH(2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata (grant_code),
        .rdata (ev_code),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: stimulus queues expected key codes, a
// negedge monitor pops and compares every accepted event.
module tb_key_event_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [3:0]    keys_pulse;
    logic          clear_ovf;
    logic          ev_ready;
    logic          ev_valid;
    logic [1:0]    ev_code;
    logic [CW-1:0] count;
    logic          overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [1:0]  exp_q[$];

    key_event_queue #(.DEPTH(DEPTH)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .keys_pulse (keys_pulse),
        .clear_ovf  (clear_ovf),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    // Pulse then one idle cycle, so each event is pushed before the next arrives.
    task automatic pulse_gap(input logic [3:0] bits);
        keys_pulse = bits;
        tick();
        keys_pulse = '0;
        tick();
    endtask

    task automatic check_idle(input string name);
        check({name, "_count"}, int'(count), 0);
        check({name, "_valid"}, int'(ev_valid), 0);
        check({name, "_code"}, int'(ev_code), 0);
        check({name, "_ovf"}, int'(overflow), 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", int'(ev_code), -1);
            end else begin
                check("event_code", int'(ev_code), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        keys_pulse = '0;
        clear_ovf  = 1'b0;
        ev_ready   = 1'b0;
        #3;
        check_idle("reset");
        tick();
        tick();
        reset = 1'b0;

        // Single event with consumer ready: visible for exactly one cycle.
        ev_ready = 1'b1;
        exp_q.push_back(2'd2);
        keys_pulse = 4'b0100;
        tick();
        keys_pulse = '0;
        check("single_pending_count", int'(count), 0);
        check("single_pending_valid", int'(ev_valid), 0);
        tick();
        check("single_count1", int'(count), 1);
        check("single_valid1", int'(ev_valid), 1);
        check("single_code", int'(ev_code), 2);
        tick();
        check("single_count0", int'(count), 0);
        check("single_valid0", int'(ev_valid), 0);

        // Re-pulse of the key being granted is kept as a second event.
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        keys_pulse = 4'b0001;
        tick();
        tick();
        keys_pulse = '0;
        repeat (4) tick();
        check("repulse_ovf", int'(overflow), 0);
        check("repulse_count", int'(count), 0);

        // Simultaneous pulses serialize in index order.
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        keys_pulse = 4'b1111;
        tick();
        keys_pulse = '0;
        repeat (3) tick();
        check("simul_count3", int'(count), 3);
        tick();
        check("simul_count4", int'(count), 4);
        check("simul_head", int'(ev_code), 0);
        ev_ready = 1'b1;
        repeat (5) tick();
        check("simul_drained", int'(count), 0);

        // Fill to DEPTH with backpressure; 9th stays pending, 10th drops.
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(2'd1);
        for (int i = 0; i < 9; i++) pulse_gap(4'b0010);
        check("full_count", int'(count), 8);
        check("full_valid", int'(ev_valid), 1);
        check("full_ovf0", int'(overflow), 0);
        keys_pulse = 4'b0010;
        tick();
        keys_pulse = '0;
        check("drop_ovf1", int'(overflow), 1);
        check("drop_count", int'(count), 8);

        // Overflow clear, then clear coinciding with a new drop.
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_ovf0", int'(overflow), 0);
        keys_pulse = 4'b0010;
        tick();
        check("redrop_ovf1", int'(overflow), 1);
        clear_ovf = 1'b1;
        tick();
        keys_pulse = '0;
        check("clear_with_drop_ovf1", int'(overflow), 1);
        tick();
        clear_ovf = 1'b0;
        check("clear_again_ovf0", int'(overflow), 0);
        ev_ready = 1'b1;
        repeat (11) tick();
        check("full_drained", int'(count), 0);

        // Full with concurrent pop: pending key 3 enters at the tail.
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        for (int i = 0; i < 8; i++) pulse_gap(4'b0001);
        keys_pulse = 4'b1000;
        tick();
        keys_pulse = '0;
        tick();
        check("tail_pre_count", int'(count), 8);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("tail_pushpop_count", int'(count), 8);
        check("tail_ovf", int'(overflow), 0);
        ev_ready = 1'b1;
        repeat (9) tick();
        check("tail_drained", int'(count), 0);
        check("tail_all_seen", exp_q.size(), 0);

        // Asynchronous reset mid-stream discards queued and pending events.
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse_gap(4'b0100);
        keys_pulse = 4'b0011;
        tick();
        keys_pulse = '0;
        check("prereset_count", int'(count), 5);
        #1;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        keys_pulse = 4'b1111;
        tick();
        tick();
        keys_pulse = '0;
        reset = 1'b0;
        check_idle("in_reset");

        // First edge after release samples normally; nothing stale follows.
        exp_q.push_back(2'd3);
        keys_pulse = 4'b1000;
        tick();
        keys_pulse = '0;
        tick();
        check("post_reset_count", int'(count), 1);
        check("post_reset_code", int'(ev_code), 3);
        ev_ready = 1'b1;
        repeat (6) tick();
        check("post_reset_empty", int'(count), 0);
        check("post_reset_valid", int'(ev_valid), 0);
        check("all_events_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
